// File: rtl/debounce_pulse.sv
// debounce_pulse: push-button debouncer that emits a one-cycle toggle request.
//
// The raw button is synchronized with two flops. A four-state FSM then qualifies
// each level change. A new level is accepted only after DEBOUNCE_CYCLES
// consecutive synchronized samples agree. An accepted press produces a
// one-cycle enable pulse.
//
// Optional feature: define RELEASE_PULSE_EN to pulse enable on an accepted
// release as well. The downstream toggle flop then changes on press and again
// on release. With the macro undefined, only presses pulse.
//
// Parameters:
//   DEBOUNCE_CYCLES - consecutive stable samples needed to accept a change (2..255)
//   CNT_W           - width of the stability counter
//
// Ports:
//   clk    in  system clock, rising edge
//   reset  in  asynchronous active-low reset
//   btn    in  raw asynchronous button level
//   enable out one-cycle toggle-request pulse
//   level  out debounced button level
//   busy   out high while a candidate change is being qualified
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | stable low
// WAIT_HIGH | btn_s high, counting stable high samples
// HIGH      | stable high
// WAIT_LOW  | btn_s low, counting stable low samples

module debounce_pulse #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic enable,
  output logic level,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

`ifdef RELEASE_PULSE_EN
  localparam logic RELEASE_PULSE = 1'b1;
`else
  localparam logic RELEASE_PULSE = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic           sync_1;
  logic           btn_s;
  state_t         state;
  state_t         state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic           enable_d;
  logic           level_d;
  logic           busy_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_1 <= 1'b0;
      btn_s  <= 1'b0;
      state  <= IDLE;
      cnt    <= '0;
      enable <= 1'b0;
      level  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      sync_1 <= btn;
      btn_s  <= sync_1;
      state  <= state_d;
      cnt    <= cnt_d;
      enable <= enable_d;
      level  <= level_d;
      busy   <= busy_d;
    end
  end

  // The outputs are registered copies of values derived from the next state.
  // level and busy therefore change on the same edge as the state itself.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    enable_d = 1'b0;

    case (state)
      IDLE: begin
        if (btn_s) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end

      WAIT_HIGH: begin
        if (!btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt >= CNT_LAST) begin
          state_d  = HIGH;
          cnt_d    = '0;
          enable_d = 1'b1;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end

      HIGH: begin
        if (!btn_s) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end

      WAIT_LOW: begin
        if (btn_s) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt >= CNT_LAST) begin
          state_d  = IDLE;
          cnt_d    = '0;
          enable_d = RELEASE_PULSE;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    level_d = (state_d == HIGH) || (state_d == WAIT_LOW);
    busy_d  = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
  end

endmodule

// File: tb/tb_debounce_pulse.sv
module tb_debounce_pulse;

  localparam int D = 4;

`ifdef RELEASE_PULSE_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif

  logic clk;
  logic reset;
  logic btn;
  logic enable;
  logic level;
  logic busy;

  int vectors;
  int miscompares;
  int cyc;
  int pulse_cnt;
  int last_pulse;
  int busy_seen;
  bit prev_en;

  debounce_pulse #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .btn    (btn),
    .enable (enable),
    .level  (level),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model. The synchronizer is treated as a two-sample delay.
  // run counts the consecutive delayed samples that disagree with the
  // accepted level. Reaching D flips the level.
  bit hist1, hist2;
  int m_run;
  bit m_level, m_en, m_busy;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist1 = 0; hist2 = 0;
      m_run = 0; m_level = 0; m_en = 0; m_busy = 0;
    end else begin
      m_en = 0;
      if (hist2 != m_level) begin
        m_run = m_run + 1;
        if (m_run >= D) begin
          m_level = !m_level;
          m_run = 0;
          m_en = m_level ? 1'b1 : REL;
        end
      end else begin
        m_run = 0;
      end
      m_busy = (m_run != 0);
      hist2 = hist1;
      hist1 = btn;
    end
  end

  always @(negedge clk) begin
    vectors = vectors + 3;
    if (enable !== m_en) begin
      miscompares++;
      $display("FAIL model_enable cyc=%0d got=%b exp=%b", cyc, enable, m_en);
    end
    if (level !== m_level) begin
      miscompares++;
      $display("FAIL model_level cyc=%0d got=%b exp=%b", cyc, level, m_level);
    end
    if (busy !== m_busy) begin
      miscompares++;
      $display("FAIL model_busy cyc=%0d got=%b exp=%b", cyc, busy, m_busy);
    end
    if (enable === 1'b1) begin
      vectors++;
      if (prev_en) begin
        miscompares++;
        $display("FAIL enable_back_to_back cyc=%0d got=11 exp=10", cyc);
      end
      pulse_cnt++;
      last_pulse = cyc;
    end
    if (busy === 1'b1) busy_seen++;
    prev_en = (enable === 1'b1);
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clr();
    pulse_cnt = 0;
    last_pulse = -1;
    busy_seen = 0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1 reset = 1'b1;
  endtask

  int e1;

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; prev_en = 0;
    clr();
    reset = 1'b0;
    btn = 1'b1;

    // Reset held with btn high: all outputs stay low
    step(1);
    for (int i = 0; i < 5; i++) begin
      chk("rst_enable", enable, 0);
      chk("rst_level", level, 0);
      chk("rst_busy", busy, 0);
      step(1);
    end
    btn = 1'b0;
    step(3);
    release_reset();
    step(2);

    // Clean press: one pulse at edge 6 counted from the sampling edge
    clr();
    e1 = cyc + 1;
    btn = 1'b1;
    step(10);
    chk("press_pulses", pulse_cnt, 1);
    chk("press_edge", last_pulse - e1 + 1, 6);
    chk("press_level", level, 1);
    btn = 1'b0;
    step(10);
    chk("release_level", level, 0);

    // Short glitch: busy seen, but no pulse and no level change
    clr();
    btn = 1'b1;
    step(2);
    btn = 1'b0;
    step(10);
    chk("glitch_pulses", pulse_cnt, 0);
    chk("glitch_level", level, 0);
    chk("glitch_busy_seen", busy_seen > 0, 1);

    // Bounce 1/0/1/0, then hold high
    clr();
    btn = 1'b1; step(1);
    btn = 1'b0; step(1);
    btn = 1'b1; step(1);
    btn = 1'b0; step(1);
    e1 = cyc + 1;
    btn = 1'b1;
    step(10);
    chk("bounce_pulses", pulse_cnt, 1);
    chk("bounce_edge", last_pulse - e1 + 1, 6);
    btn = 1'b0;
    step(10);

    // Reset while qualifying a press (cnt=2)
    clr();
    btn = 1'b1;
    step(4);
    chk("midq_busy_before", busy, 1);
    #1 reset = 1'b0;
    #1;
    chk("midq_busy_async", busy, 0);
    chk("midq_level_async", level, 0);
    chk("midq_enable_async", enable, 0);
    step(3);
    btn = 1'b0;
    release_reset();
    step(10);
    chk("midq_pulses", pulse_cnt, 0);

    // Reset released with btn already high counts as a fresh press
    btn = 1'b1;
    #1 reset = 1'b0;
    step(3);
    clr();
    release_reset();
    e1 = cyc + 1;
    step(10);
    chk("rst_high_pulses", pulse_cnt, 1);
    chk("rst_high_edge", last_pulse - e1 + 1, 6);
    btn = 1'b0;
    step(10);

    // Full press and release: the release pulses only with the macro
    clr();
    btn = 1'b1;
    step(10);
    btn = 1'b0;
    step(10);
    chk("press_release_pulses", pulse_cnt, REL ? 2 : 1);
    chk("press_release_level", level, 0);

    // Random bursts with occasional asynchronous resets
    for (int i = 0; i < 400; i++) begin
      btn = $urandom_range(0, 1);
      step($urandom_range(1, 8));
      if ($urandom_range(0, 49) == 0) begin
        #1 reset = 1'b0;
        step($urandom_range(1, 3));
        release_reset();
      end
    end
    btn = 1'b0;
    step(12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
